ahb_sram_slave: RTL and testbench

AHB-Lite memory slave with configurable wait states and an ERROR response path. It sits directly downstream of the AHB master and address decoder: it consumes HADDR/HWRITE/HSIZE/HTRANS/HWDATA under its HSEL and returns HRDATA, HREADYOUT and HRESP to the response multiplexer. Storage is a word-organised, byte-writable flop array with little-endian lanes.

---
 rtl/ahb_lite_pkg.sv | 31 +++
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_byte_lane_dec.sv | 20 ++
 rtl/ahb_sram_slave.sv | 126 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite encodings and slave state type
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Illegal size, or a half/word transfer not aligned to its own size.
  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && addr_lo[0]) ||
           ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite slave port bundle
interface ahb_sram_slave_if;

  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, htrans, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, htrans, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_byte_lane_dec.sv
// rtl/ahb_byte_lane_dec.sv - HSIZE and low address bits to little-endian byte strobe
module ahb_byte_lane_dec
  import ahb_lite_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);

  always_comb begin
    strb_o = 4'b0000;
    case (hsize_i)
      HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
      HSIZE_HALF: strb_o = addr_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb_o = 4'b1111;
      default:    strb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite byte-writable SRAM slave with wait states and ERROR response
module ahb_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic             hclk_i,
  input logic             hreset_i,
  ahb_sram_slave_if.slave bus
);

  localparam int          AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_DEPTH);
  localparam logic [2:0]  WS         = 3'(WAIT_STATES);

  slave_state_e  state_q;
  logic [2:0]    wait_cnt_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    strb_q;
  logic          write_q;
  logic          hreadyout_q;
  logic          hresp_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   mem_q [MEM_DEPTH];

  logic          accept;
  logic          addr_err;
  logic          commit;
  logic [3:0]    strb_d;
  logic [AW-1:0] haddr_idx;
  logic [AW-1:0] rd_idx_d;
  logic [31:0]   rd_word_d;
  logic          unused_hburst;

  assign accept    = bus.hsel & bus.hready &
                     ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign addr_err  = ({1'b0, bus.haddr} >= ADDR_LIMIT) ||
                     size_misaligned(bus.hsize, bus.haddr[1:0]);
  assign haddr_idx = bus.haddr[AW+1:2];
  assign commit    = (state_q == ST_DATA) && write_q;
  assign rd_idx_d  = (state_q == ST_WAIT) ? addr_q : haddr_idx;
  assign unused_hburst = ^bus.hburst;

  ahb_byte_lane_dec u_lane_dec (
    .hsize_i (bus.hsize),
    .addr_i  (bus.haddr[1:0]),
    .strb_o  (strb_d)
  );

  // A write committing on this edge must be visible to a read accepted on the same edge.
  always_comb begin
    rd_word_d = mem_q[rd_idx_d];
    if (commit && (addr_q == rd_idx_d)) begin
      for (int l = 0; l < 4; l++) begin
        if (strb_q[l]) rd_word_d[8*l +: 8] = bus.hwdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      hrdata_q <= '0;
      if (commit) begin
        for (int l = 0; l < 4; l++) begin
          if (strb_q[l]) mem_q[addr_q][8*l +: 8] <= bus.hwdata[8*l +: 8];
        end
      end
      case (state_q)
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 3'd1;
          if (wait_cnt_q <= 3'd1) begin
            state_q     <= ST_DATA;
            hreadyout_q <= 1'b1;
            hrdata_q    <= write_q ? '0 : rd_word_d;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            addr_q  <= haddr_idx;
            strb_q  <= strb_d;
            write_q <= bus.hwrite & ~addr_err;
            if (addr_err) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WS != 3'd0) begin
              state_q     <= ST_WAIT;
              wait_cnt_q  <= WS;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state_q     <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
              hrdata_q    <= bus.hwrite ? '0 : rd_word_d;
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave (0 and 2 wait states)
module tb_ahb_sram_slave;
  import ahb_lite_pkg::*;

  logic hclk = 1'b0;
  logic hreset;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus2 ();

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk_i(hclk), .hreset_i(hreset), .bus(bus0.slave)
  );
  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .hclk_i(hclk), .hreset_i(hreset), .bus(bus2.slave)
  );

  always #5 hclk = ~hclk;

  logic        use2;
  logic        hsel_v;
  logic        hwrite_v;
  logic [31:0] haddr_v;
  logic [31:0] hwdata_v;
  logic [2:0]  hsize_v;
  logic [1:0]  htrans_v;
  logic [2:0]  hburst_v;

  assign bus0.hsel   = hsel_v & ~use2;
  assign bus2.hsel   = hsel_v & use2;
  assign bus0.haddr  = haddr_v;   assign bus2.haddr  = haddr_v;
  assign bus0.hwrite = hwrite_v;  assign bus2.hwrite = hwrite_v;
  assign bus0.hsize  = hsize_v;   assign bus2.hsize  = hsize_v;
  assign bus0.htrans = htrans_v;  assign bus2.htrans = htrans_v;
  assign bus0.hburst = hburst_v;  assign bus2.hburst = hburst_v;
  assign bus0.hwdata = hwdata_v;  assign bus2.hwdata = hwdata_v;
  assign bus0.hready = bus0.hreadyout;
  assign bus2.hready = bus2.hreadyout;

  logic        cur_ready;
  logic        cur_resp;
  logic [31:0] cur_rdata;
  assign cur_ready = use2 ? bus2.hreadyout : bus0.hreadyout;
  assign cur_resp  = use2 ? bus2.hresp     : bus0.hresp;
  assign cur_rdata = use2 ? bus2.hrdata    : bus0.hrdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [0:1][0:1023];

  function automatic bit model_err(input logic [2:0] sz, input logic [31:0] a);
    int unsigned nbytes;
    if (sz > 3'd2) return 1'b1;
    if (a >= 32'd1024) return 1'b1;
    nbytes = 1 << sz;
    return (a % nbytes) != 0;
  endfunction

  task automatic model_write(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int ba;
    for (int i = 0; i < (1 << sz); i++) begin
      ba = int'(a) + i;
      ref_mem[d][ba] = wd[8*(ba % 4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int base;
    base = int'(a) & ~3;
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  task automatic xfer(input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      output int waits, output logic rf, output logic rl, output logic [31:0] rd);
    hsel_v = 1'b1; hwrite_v = w; hsize_v = sz; haddr_v = a; htrans_v = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    htrans_v = HTRANS_IDLE;
    hwdata_v = wd;
    waits = 0;
    rf = cur_resp;
    while (cur_ready !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge hclk); #1;
    end
    rl = cur_resp;
    rd = cur_rdata;
  endtask

  task automatic test_reset();
    hreset = 1'b1; use2 = 1'b0; hsel_v = 1'b0; hwrite_v = 1'b0; haddr_v = '0;
    hsize_v = HSIZE_WORD; htrans_v = HTRANS_IDLE; hburst_v = 3'd0; hwdata_v = '0;
    repeat (2) @(posedge hclk);
    #1;
    total++;
    if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_during_ws0 got=%b/%b/%h exp=1/0/0", bus0.hreadyout, bus0.hresp, bus0.hrdata);
    end
    total++;
    if ({bus2.hreadyout, bus2.hresp, bus2.hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_during_ws2 got=%b/%b/%h exp=1/0/0", bus2.hreadyout, bus2.hresp, bus2.hrdata);
    end
    hreset = 1'b0;
    @(posedge hclk); #1;
    total++;
    if ({bus0.hreadyout, bus0.hresp, bus0.hrdata, bus2.hreadyout, bus2.hresp, bus2.hrdata} !==
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_after got=%b/%b/%h %b/%b/%h exp=1/0/0 1/0/0",
                      bus0.hreadyout, bus0.hresp, bus0.hrdata, bus2.hreadyout, bus2.hresp, bus2.hrdata);
    end
  endtask

  task automatic test_word_rw();
    int w; logic rf, rl; logic [31:0] rd;
    use2 = 1'b0;
    xfer(1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, w, rf, rl, rd);
    model_write(0, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    total++;
    if (w != 0 || rl !== 1'b0) begin
      bad++; $display("FAIL word_write_resp got waits=%0d resp=%b exp waits=0 resp=0", w, rl);
    end
    xfer(1'b0, HSIZE_WORD, 32'h10, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== 32'hDEADBEEF || w != 0 || rl !== 1'b0) begin
      bad++; $display("FAIL word_read got=%h waits=%0d resp=%b exp=deadbeef waits=0 resp=0", rd, w, rl);
    end
  endtask

  task automatic test_byte_half();
    int w; logic rf, rl; logic [31:0] rd;
    use2 = 1'b0;
    xfer(1'b1, HSIZE_WORD, 32'h10, 32'h11223344, w, rf, rl, rd);
    model_write(0, HSIZE_WORD, 32'h10, 32'h11223344);
    xfer(1'b1, HSIZE_BYTE, 32'h13, {4{8'hAA}}, w, rf, rl, rd);
    model_write(0, HSIZE_BYTE, 32'h13, {4{8'hAA}});
    xfer(1'b0, HSIZE_WORD, 32'h10, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== 32'hAA223344 || rd !== model_read(0, 32'h10)) begin
      bad++; $display("FAIL byte_lane got=%h exp=aa223344", rd);
    end
    xfer(1'b1, HSIZE_HALF, 32'h10, {2{16'h5566}}, w, rf, rl, rd);
    model_write(0, HSIZE_HALF, 32'h10, {2{16'h5566}});
    xfer(1'b0, HSIZE_BYTE, 32'h12, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== 32'hAA225566 || rd !== model_read(0, 32'h10)) begin
      bad++; $display("FAIL half_lane got=%h exp=aa225566", rd);
    end
  endtask

  task automatic test_wait_states();
    int w; logic rf, rl; logic [31:0] rd, val;
    use2 = 1'b1;
    val = $urandom;
    xfer(1'b1, HSIZE_WORD, 32'h20, val, w, rf, rl, rd);
    model_write(1, HSIZE_WORD, 32'h20, val);
    total++;
    if (w != 2 || rf !== 1'b0 || rl !== 1'b0) begin
      bad++; $display("FAIL ws2_write got waits=%0d resp=%b/%b exp waits=2 resp=0/0", w, rf, rl);
    end
    hsel_v = 1'b1; hwrite_v = 1'b0; hsize_v = HSIZE_WORD; haddr_v = 32'h20; htrans_v = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    htrans_v = HTRANS_IDLE;
    for (int c = 1; c <= 2; c++) begin
      total++;
      if ({cur_ready, cur_resp, cur_rdata} !== {1'b0, 1'b0, 32'h0}) begin
        bad++; $display("FAIL ws2_wait_cycle%0d got=%b/%b/%h exp=0/0/0", c, cur_ready, cur_resp, cur_rdata);
      end
      @(posedge hclk); #1;
    end
    total++;
    if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, model_read(1, 32'h20)}) begin
      bad++; $display("FAIL ws2_data got=%b/%b/%h exp=1/0/%h", cur_ready, cur_resp, cur_rdata, model_read(1, 32'h20));
    end
  endtask

  task automatic test_error();
    int w; logic rf, rl; logic [31:0] rd;
    use2 = 1'b0;
    xfer(1'b1, HSIZE_WORD, 32'h0, 32'hCAFEF00D, w, rf, rl, rd);
    model_write(0, HSIZE_WORD, 32'h0, 32'hCAFEF00D);
    hsel_v = 1'b1; hwrite_v = 1'b1; hsize_v = HSIZE_WORD; haddr_v = 32'h400; htrans_v = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    htrans_v = HTRANS_IDLE; hwdata_v = 32'h12345678;
    total++;
    if ({cur_ready, cur_resp} !== 2'b01) begin
      bad++; $display("FAIL err1_oob got=%b/%b exp=0/1", cur_ready, cur_resp);
    end
    @(posedge hclk); #1;
    total++;
    if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL err2_oob got=%b/%b/%h exp=1/1/0", cur_ready, cur_resp, cur_rdata);
    end
    @(posedge hclk); #1;
    total++;
    if ({cur_ready, cur_resp} !== 2'b10) begin
      bad++; $display("FAIL err_then_idle got=%b/%b exp=1/0", cur_ready, cur_resp);
    end
    xfer(1'b1, HSIZE_HALF, 32'h01, 32'h99999999, w, rf, rl, rd);
    total++;
    if (w != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      bad++; $display("FAIL misaligned_half got waits=%0d resp=%b/%b exp waits=1 resp=1/1", w, rf, rl);
    end
    xfer(1'b1, 3'd3, 32'h0, 32'h77777777, w, rf, rl, rd);
    total++;
    if (w != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      bad++; $display("FAIL bad_size got waits=%0d resp=%b/%b exp waits=1 resp=1/1", w, rf, rl);
    end
    xfer(1'b0, HSIZE_WORD, 32'h0, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== model_read(0, 32'h0) || rl !== 1'b0) begin
      bad++; $display("FAIL err_no_write got=%h exp=%h", rd, model_read(0, 32'h0));
    end
    xfer(1'b1, HSIZE_WORD, 32'h3FC, 32'h0BADF00D, w, rf, rl, rd);
    model_write(0, HSIZE_WORD, 32'h3FC, 32'h0BADF00D);
    xfer(1'b0, HSIZE_WORD, 32'h3FC, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== 32'h0BADF00D || rl !== 1'b0 || w != 0) begin
      bad++; $display("FAIL last_word got=%h resp=%b waits=%0d exp=0badf00d resp=0 waits=0", rd, rl, w);
    end
    use2 = 1'b1;
    xfer(1'b0, HSIZE_WORD, 32'h1000, 32'h0, w, rf, rl, rd);
    total++;
    if (w != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      bad++; $display("FAIL ws2_err got waits=%0d resp=%b/%b exp waits=1 resp=1/1", w, rf, rl);
    end
  endtask

  task automatic test_back_to_back();
    int w; logic rf, rl; logic [31:0] rd;
    use2 = 1'b0;
    xfer(1'b1, HSIZE_WORD, 32'h0, 32'hFFFF0000, w, rf, rl, rd);
    hsel_v = 1'b1; hwrite_v = 1'b1; hsize_v = HSIZE_WORD; haddr_v = 32'h0; htrans_v = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    hwdata_v = 32'h1; hwrite_v = 1'b0; htrans_v = HTRANS_NONSEQ;
    model_write(0, HSIZE_WORD, 32'h0, 32'h1);
    total++;
    if ({cur_ready, cur_resp} !== 2'b10) begin
      bad++; $display("FAIL b2b_write_data got=%b/%b exp=1/0", cur_ready, cur_resp);
    end
    @(posedge hclk); #1;
    htrans_v = HTRANS_IDLE;
    total++;
    if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, 32'h1}) begin
      bad++; $display("FAIL b2b_read_data got=%b/%b/%h exp=1/0/00000001", cur_ready, cur_resp, cur_rdata);
    end
    @(posedge hclk); #1;
    total++;
    if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL b2b_idle got=%b/%b/%h exp=1/0/0", cur_ready, cur_resp, cur_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    int w; logic rf, rl; logic [31:0] rd, pre;
    use2 = 1'b1;
    pre = $urandom;
    xfer(1'b1, HSIZE_WORD, 32'h40, pre, w, rf, rl, rd);
    model_write(1, HSIZE_WORD, 32'h40, pre);
    hsel_v = 1'b1; hwrite_v = 1'b1; hsize_v = HSIZE_WORD; haddr_v = 32'h40; htrans_v = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    htrans_v = HTRANS_IDLE; hwdata_v = ~pre;
    hreset = 1'b1;
    #1;
    total++;
    if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_mid_write got=%b/%b/%h exp=1/0/0", cur_ready, cur_resp, cur_rdata);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    xfer(1'b0, HSIZE_WORD, 32'h40, 32'h0, w, rf, rl, rd);
    total++;
    if (rd !== pre) begin
      bad++; $display("FAIL reset_drops_write got=%h exp=%h", rd, pre);
    end
  endtask

  task automatic test_random();
    int w, r, ew; logic rf, rl; logic [31:0] rd, a, wd; logic [2:0] sz; bit wr, err;
    for (int d = 0; d < 2; d++) begin
      use2 = (d == 1);
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        xfer(1'b1, HSIZE_WORD, 32'(4 * i), wd, w, rf, rl, rd);
        model_write(d, HSIZE_WORD, 32'(4 * i), wd);
      end
      for (int n = 0; n < 80; n++) begin
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
        a  = ($urandom_range(0, 14) == 0) ? 32'(1024 + $urandom_range(0, 255)) : 32'($urandom_range(0, 63));
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        hburst_v = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) begin
          hsel_v = 1'($urandom_range(0, 1)); htrans_v = 2'($urandom_range(0, 1));
          @(posedge hclk); #1;
          total++;
          if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL rand_idle d=%0d got=%b/%b/%h exp=1/0/0", d, cur_ready, cur_resp, cur_rdata);
          end
        end
        err = model_err(sz, a);
        xfer(wr, sz, a, wd, w, rf, rl, rd);
        ew = err ? 1 : (d == 1 ? 2 : 0);
        total++;
        if (w != ew || rf !== err || rl !== err ||
            (!err && !wr && rd !== model_read(d, a)) || (err && rd !== 32'h0)) begin
          bad++;
          $display("FAIL rand d=%0d n=%0d wr=%0d sz=%0d a=%h got waits=%0d resp=%b/%b rd=%h exp waits=%0d resp=%b rd=%h",
                   d, n, wr, sz, a, w, rf, rl, rd, ew, err, err ? 32'h0 : model_read(d, a));
        end
        if (!err && wr) model_write(d, sz, a, wd);
      end
      htrans_v = HTRANS_IDLE;
      @(posedge hclk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
